vga_draw_arbiter: RTL and testbench



---
 rtl/vga_draw_arbiter.sv | 145 ++++++++++++++
 tb/tb_vga_draw_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter
//
// Registered two-client pixel-write arbiter that sits in front of vga_adapter.
// The obstacle manager and the player object each stream pixels under a
// req/ack handshake. A client keeps ownership for a whole burst (up to its
// *_last pixel), so an erase/redraw sequence is never interleaved with the
// other client's pixels. Ties from idle are broken round-robin. A grant is
// force-released after HOLD_MAX cycles so that a stuck client cannot starve
// the other one.
//
// Ports:
//   Clock, Resetn                 clock, asynchronous active-low reset
//   obs_req/x/y/color/last/ack    obstacle client pixel stream
//   plr_req/x/y/color/last/ack    player client pixel stream
//   VGA_x/VGA_y/VGA_color         registered pixel to vga_adapter
//   VGA_write                     registered write strobe
//   owner                         00 idle, 01 obstacle, 10 player
//   clipped                       one-cycle pulse: accepted pixel was out of range
module vga_draw_arbiter #(
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLOR_DEPTH = 9,
    parameter int X_MAX       = 640,
    parameter int Y_MAX       = 480,
    parameter int HOLD_MAX    = 4096
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   obs_req,
    input  logic [nX-1:0]          obs_x,
    input  logic [nY-1:0]          obs_y,
    input  logic [COLOR_DEPTH-1:0] obs_color,
    input  logic                   obs_last,
    output logic                   obs_ack,
    input  logic                   plr_req,
    input  logic [nX-1:0]          plr_x,
    input  logic [nY-1:0]          plr_y,
    input  logic [COLOR_DEPTH-1:0] plr_color,
    input  logic                   plr_last,
    output logic                   plr_ack,
    output logic [nX-1:0]          VGA_x,
    output logic [nY-1:0]          VGA_y,
    output logic [COLOR_DEPTH-1:0] VGA_color,
    output logic                   VGA_write,
    output logic [1:0]             owner,
    output logic                   clipped
);

    localparam int HOLD_W = $clog2(HOLD_MAX) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        G_OBS = 2'b01,
        G_PLR = 2'b10
    } state_t;

    state_t              state, state_next;
    logic                last_plr;      // 1: player owned the last completed grant
    logic [HOLD_W-1:0]   hold_cnt;

    logic                   xfer_p0;
    logic                   last_p0;
    logic                   clip_p0;
    logic [nX-1:0]          pix_x_p0;
    logic [nY-1:0]          pix_y_p0;
    logic [COLOR_DEPTH-1:0] pix_color_p0;
    logic                   hold_expired;
    logic                   release_grant;

    // Unsigned full-width range check against the first illegal coordinate.
    function automatic logic out_of_range(input logic [nX-1:0] x, input logic [nY-1:0] y);
        return (32'(x) >= 32'($unsigned(X_MAX))) || (32'(y) >= 32'($unsigned(Y_MAX)));
    endfunction

    assign owner = state;

    // ---- p0: grant decode, pixel select, next-state ----
    always_comb begin
        obs_ack      = (state == G_OBS) && obs_req;
        plr_ack      = (state == G_PLR) && plr_req;
        xfer_p0      = obs_ack || plr_ack;
        pix_x_p0     = plr_ack ? plr_x     : obs_x;
        pix_y_p0     = plr_ack ? plr_y     : obs_y;
        pix_color_p0 = plr_ack ? plr_color : obs_color;
        last_p0      = plr_ack ? plr_last  : obs_last;
        clip_p0      = out_of_range(pix_x_p0, pix_y_p0);

        // Timeout fires on the HOLD_MAX-th grant cycle even while stalled.
        hold_expired  = (state != IDLE) && (hold_cnt == HOLD_W'(HOLD_MAX - 1));
        release_grant = (xfer_p0 && last_p0) || hold_expired;

        state_next = state;
        case (state)
            IDLE: begin
                if (obs_req && plr_req)
                    state_next = last_plr ? G_OBS : G_PLR;
                else if (obs_req)
                    state_next = G_OBS;
                else if (plr_req)
                    state_next = G_PLR;
            end
            G_OBS: if (release_grant) state_next = plr_req ? G_PLR : IDLE;
            G_PLR: if (release_grant) state_next = obs_req ? G_OBS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            last_plr <= 1'b1;
            hold_cnt <= '0;
        end else begin
            state <= state_next;
            if (release_grant)
                last_plr <= (state == G_PLR);
            // A release always changes state, so staying put means the
            // same grant continues; any entry or idle restarts the count.
            if ((state_next == state) && (state != IDLE))
                hold_cnt <= hold_cnt + HOLD_W'(1);
            else
                hold_cnt <= '0;
        end
    end

    // ---- p1: registered pixel to vga_adapter ----
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            VGA_x     <= '0;
            VGA_y     <= '0;
            VGA_color <= '0;
            VGA_write <= 1'b0;
            clipped   <= 1'b0;
        end else begin
            VGA_write <= xfer_p0 && !clip_p0;
            clipped   <= xfer_p0 && clip_p0;
            if (xfer_p0 && !clip_p0) begin
                VGA_x     <= pix_x_p0;
                VGA_y     <= pix_y_p0;
                VGA_color <= pix_color_p0;
            end
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter
//
// Directed testbench for vga_draw_arbiter with HOLD_MAX = 8. Each task
// drives one scenario cycle by cycle: inputs are applied 1 time unit after
// the rising edge and outputs are sampled 1 time unit later. The packed
// status word is {obs_ack, plr_ack, VGA_write, clipped, owner[1:0]}.
module tb_vga_draw_arbiter;

    logic       Clock;
    logic       Resetn;
    logic       obs_req, obs_last, obs_ack;
    logic [9:0] obs_x;
    logic [8:0] obs_y, obs_color;
    logic       plr_req, plr_last, plr_ack;
    logic [9:0] plr_x;
    logic [8:0] plr_y, plr_color;
    logic [9:0] VGA_x;
    logic [8:0] VGA_y, VGA_color;
    logic       VGA_write, clipped;
    logic [1:0] owner;
    logic [5:0] status;

    int n_chk;
    int n_fail;

    vga_draw_arbiter #(
        .nX(10), .nY(9), .COLOR_DEPTH(9), .X_MAX(640), .Y_MAX(480), .HOLD_MAX(8)
    ) dut (
        .Clock(Clock), .Resetn(Resetn),
        .obs_req(obs_req), .obs_x(obs_x), .obs_y(obs_y), .obs_color(obs_color),
        .obs_last(obs_last), .obs_ack(obs_ack),
        .plr_req(plr_req), .plr_x(plr_x), .plr_y(plr_y), .plr_color(plr_color),
        .plr_last(plr_last), .plr_ack(plr_ack),
        .VGA_x(VGA_x), .VGA_y(VGA_y), .VGA_color(VGA_color), .VGA_write(VGA_write),
        .owner(owner), .clipped(clipped)
    );

    assign status = {obs_ack, plr_ack, VGA_write, clipped, owner};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drv_obs(input logic r, input logic [9:0] x, input logic [8:0] y,
                           input logic [8:0] c, input logic l);
        obs_req = r; obs_x = x; obs_y = y; obs_color = c; obs_last = l;
    endtask

    task automatic drv_plr(input logic r, input logic [9:0] x, input logic [8:0] y,
                           input logic [8:0] c, input logic l);
        plr_req = r; plr_x = x; plr_y = y; plr_color = c; plr_last = l;
    endtask

    task automatic apply_reset();
        Resetn = 1'b0;
        drv_obs(1'b0, 10'd0, 9'd0, 9'd0, 1'b0);
        drv_plr(1'b0, 10'd0, 9'd0, 9'd0, 1'b0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        drv_obs(1'b1, 10'd3, 9'd4, 9'h1FF, 1'b1);
        drv_plr(1'b1, 10'd5, 9'd6, 9'h1FF, 1'b1);
        repeat (2) @(posedge Clock);
        #1;
        n_chk++; if (status !== 6'b000000) begin n_fail++; $display("FAIL reset_status: got %b expected %b", status, 6'b000000); end
        n_chk++; if ({VGA_x, VGA_y, VGA_color} !== 28'd0) begin n_fail++; $display("FAIL reset_pixel: got %h expected 0", {VGA_x, VGA_y, VGA_color}); end
        drv_obs(1'b0, 10'd0, 9'd0, 9'd0, 1'b0);
        drv_plr(1'b0, 10'd0, 9'd0, 9'd0, 1'b0);
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic test_single_burst();
        step(); drv_obs(1'b1, 10'd10, 9'd20, 9'h1C0, 1'b0); #1;
        n_chk++; if (status !== 6'b000000) begin n_fail++; $display("FAIL burst_c0: got %b expected %b", status, 6'b000000); end
        step(); #1;
        n_chk++; if (status !== 6'b100001) begin n_fail++; $display("FAIL burst_c1: got %b expected %b", status, 6'b100001); end
        step(); drv_obs(1'b1, 10'd11, 9'd20, 9'h1C0, 1'b0); #1;
        n_chk++; if (status !== 6'b101001) begin n_fail++; $display("FAIL burst_c2: got %b expected %b", status, 6'b101001); end
        n_chk++; if ({VGA_x, VGA_y, VGA_color} !== {10'd10, 9'd20, 9'h1C0}) begin n_fail++; $display("FAIL burst_c2_pix: got %0d,%0d,%h expected 10,20,1c0", VGA_x, VGA_y, VGA_color); end
        step(); drv_obs(1'b1, 10'd12, 9'd20, 9'h1C0, 1'b1); #1;
        n_chk++; if (status !== 6'b101001) begin n_fail++; $display("FAIL burst_c3: got %b expected %b", status, 6'b101001); end
        n_chk++; if (VGA_x !== 10'd11) begin n_fail++; $display("FAIL burst_c3_x: got %0d expected 11", VGA_x); end
        step(); drv_obs(1'b0, 10'd0, 9'd0, 9'd0, 1'b0); #1;
        n_chk++; if (status !== 6'b001000) begin n_fail++; $display("FAIL burst_c4: got %b expected %b", status, 6'b001000); end
        n_chk++; if ({VGA_x, VGA_y} !== {10'd12, 9'd20}) begin n_fail++; $display("FAIL burst_c4_pix: got %0d,%0d expected 12,20", VGA_x, VGA_y); end
        step(); #1;
        n_chk++; if (status !== 6'b000000) begin n_fail++; $display("FAIL burst_c5: got %b expected %b", status, 6'b000000); end
    endtask

    task automatic test_race();
        apply_reset();
        // Simultaneous 2-pixel bursts: obstacle first after reset.
        step(); drv_obs(1'b1, 10'd1, 9'd1, 9'h001, 1'b0); drv_plr(1'b1, 10'd5, 9'd5, 9'h0AA, 1'b0); #1;
        n_chk++; if (status !== 6'b000000) begin n_fail++; $display("FAIL race_c0: got %b expected %b", status, 6'b000000); end
        step(); #1;
        n_chk++; if (status !== 6'b100001) begin n_fail++; $display("FAIL race_c1: got %b expected %b", status, 6'b100001); end
        step(); drv_obs(1'b1, 10'd2, 9'd1, 9'h002, 1'b1); #1;
        n_chk++; if (status !== 6'b101001) begin n_fail++; $display("FAIL race_c2: got %b expected %b", status, 6'b101001); end
        step(); drv_obs(1'b0, 10'd0, 9'd0, 9'd0, 1'b0); #1;
        n_chk++; if (status !== 6'b011010) begin n_fail++; $display("FAIL race_c3: got %b expected %b", status, 6'b011010); end
        n_chk++; if ({VGA_x, VGA_color} !== {10'd2, 9'h002}) begin n_fail++; $display("FAIL race_c3_pix: got %0d,%h expected 2,002", VGA_x, VGA_color); end
        step(); drv_plr(1'b1, 10'd6, 9'd5, 9'h0AB, 1'b1); #1;
        n_chk++; if (status !== 6'b011010) begin n_fail++; $display("FAIL race_c4: got %b expected %b", status, 6'b011010); end
        n_chk++; if (VGA_x !== 10'd5) begin n_fail++; $display("FAIL race_c4_x: got %0d expected 5", VGA_x); end
        step(); drv_plr(1'b0, 10'd0, 9'd0, 9'd0, 1'b0); #1;
        n_chk++; if (status !== 6'b001000) begin n_fail++; $display("FAIL race_c5: got %b expected %b", status, 6'b001000); end
        n_chk++; if ({VGA_x, VGA_color} !== {10'd6, 9'h0AB}) begin n_fail++; $display("FAIL race_c5_pix: got %0d,%h expected 6,0ab", VGA_x, VGA_color); end
        // A lone obstacle burst makes the obstacle the last owner.
        step(); drv_obs(1'b1, 10'd7, 9'd7, 9'h007, 1'b1); #1;
        step(); #1;
        n_chk++; if (status !== 6'b100001) begin n_fail++; $display("FAIL race_lone: got %b expected %b", status, 6'b100001); end
        step(); drv_obs(1'b0, 10'd0, 9'd0, 9'd0, 1'b0); #1;
        // Second race: the player is served first.
        step(); drv_obs(1'b1, 10'd8, 9'd8, 9'h008, 1'b1); drv_plr(1'b1, 10'd9, 9'd9, 9'h009, 1'b1); #1;
        step(); #1;
        n_chk++; if (status !== 6'b010010) begin n_fail++; $display("FAIL race2_c1: got %b expected %b", status, 6'b010010); end
        step(); drv_plr(1'b0, 10'd0, 9'd0, 9'd0, 1'b0); #1;
        n_chk++; if (status !== 6'b101001) begin n_fail++; $display("FAIL race2_c2: got %b expected %b", status, 6'b101001); end
        n_chk++; if (VGA_x !== 10'd9) begin n_fail++; $display("FAIL race2_c2_x: got %0d expected 9", VGA_x); end
        step(); drv_obs(1'b0, 10'd0, 9'd0, 9'd0, 1'b0); #1;
        n_chk++; if (status !== 6'b001000) begin n_fail++; $display("FAIL race2_c3: got %b expected %b", status, 6'b001000); end
    endtask

    task automatic test_stall();
        apply_reset();
        step(); drv_plr(1'b1, 10'd30, 9'd31, 9'h033, 1'b0); #1;
        step(); #1;
        n_chk++; if (status !== 6'b010010) begin n_fail++; $display("FAIL stall_c1: got %b expected %b", status, 6'b010010); end
        step(); drv_plr(1'b0, 10'd31, 9'd31, 9'h034, 1'b1); drv_obs(1'b1, 10'd50, 9'd60, 9'h111, 1'b1); #1;
        n_chk++; if (status !== 6'b001010) begin n_fail++; $display("FAIL stall_c2: got %b expected %b", status, 6'b001010); end
        for (int i = 3; i <= 6; i++) begin
            step(); #1;
            n_chk++; if (status !== 6'b000010) begin n_fail++; $display("FAIL stall_gap_c%0d: got %b expected %b", i, status, 6'b000010); end
        end
        step(); plr_req = 1'b1; #1;
        n_chk++; if (status !== 6'b010010) begin n_fail++; $display("FAIL stall_c7: got %b expected %b", status, 6'b010010); end
        step(); drv_plr(1'b0, 10'd0, 9'd0, 9'd0, 1'b0); #1;
        n_chk++; if (status !== 6'b101001) begin n_fail++; $display("FAIL stall_c8: got %b expected %b", status, 6'b101001); end
        n_chk++; if ({VGA_x, VGA_color} !== {10'd31, 9'h034}) begin n_fail++; $display("FAIL stall_c8_pix: got %0d,%h expected 31,034", VGA_x, VGA_color); end
        step(); drv_obs(1'b0, 10'd0, 9'd0, 9'd0, 1'b0); #1;
        n_chk++; if (status !== 6'b001000) begin n_fail++; $display("FAIL stall_c9: got %b expected %b", status, 6'b001000); end
        n_chk++; if (VGA_x !== 10'd50) begin n_fail++; $display("FAIL stall_c9_x: got %0d expected 50", VGA_x); end
    endtask

    task automatic test_timeout();
        apply_reset();
        step(); drv_plr(1'b1, 10'd200, 9'd100, 9'h0F0, 1'b0); #1;
        for (int i = 1; i <= 8; i++) begin
            step(); drv_obs(1'b1, 10'd70, 9'd80, 9'h0C3, 1'b1); #1;
            n_chk++;
            if (status !== ((i == 1) ? 6'b010010 : 6'b011010)) begin
                n_fail++;
                $display("FAIL timeout_c%0d: got %b expected %b", i, status, (i == 1) ? 6'b010010 : 6'b011010);
            end
        end
        step(); #1;
        n_chk++; if (status !== 6'b101001) begin n_fail++; $display("FAIL timeout_c9: got %b expected %b", status, 6'b101001); end
        step(); drv_obs(1'b0, 10'd0, 9'd0, 9'd0, 1'b0); #1;
        n_chk++; if (status !== 6'b011010) begin n_fail++; $display("FAIL timeout_c10: got %b expected %b", status, 6'b011010); end
        n_chk++; if (VGA_x !== 10'd70) begin n_fail++; $display("FAIL timeout_c10_x: got %0d expected 70", VGA_x); end
    endtask

    task automatic test_clip();
        apply_reset();
        step(); drv_obs(1'b1, 10'd639, 9'd479, 9'h1AB, 1'b0); #1;
        step(); #1;
        n_chk++; if (status !== 6'b100001) begin n_fail++; $display("FAIL clip_c1: got %b expected %b", status, 6'b100001); end
        step(); drv_obs(1'b1, 10'd640, 9'd100, 9'h0AA, 1'b0); #1;
        n_chk++; if (status !== 6'b101001) begin n_fail++; $display("FAIL clip_c2: got %b expected %b", status, 6'b101001); end
        n_chk++; if ({VGA_x, VGA_y} !== {10'd639, 9'd479}) begin n_fail++; $display("FAIL clip_c2_pix: got %0d,%0d expected 639,479", VGA_x, VGA_y); end
        step(); drv_obs(1'b1, 10'd100, 9'd480, 9'h0BB, 1'b1); #1;
        n_chk++; if (status !== 6'b100101) begin n_fail++; $display("FAIL clip_c3: got %b expected %b", status, 6'b100101); end
        n_chk++; if ({VGA_x, VGA_y, VGA_color} !== {10'd639, 9'd479, 9'h1AB}) begin n_fail++; $display("FAIL clip_c3_hold: got %0d,%0d,%h expected 639,479,1ab", VGA_x, VGA_y, VGA_color); end
        step(); drv_obs(1'b0, 10'd0, 9'd0, 9'd0, 1'b0); #1;
        n_chk++; if (status !== 6'b000100) begin n_fail++; $display("FAIL clip_c4: got %b expected %b", status, 6'b000100); end
        n_chk++; if ({VGA_x, VGA_y} !== {10'd639, 9'd479}) begin n_fail++; $display("FAIL clip_c4_hold: got %0d,%0d expected 639,479", VGA_x, VGA_y); end
        step(); #1;
        n_chk++; if (status !== 6'b000000) begin n_fail++; $display("FAIL clip_c5: got %b expected %b", status, 6'b000000); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(); drv_obs(1'b1, 10'd400, 9'd300, 9'h155, 1'b0); #1;
        step(); #1;
        n_chk++; if (status !== 6'b100001) begin n_fail++; $display("FAIL areset_c1: got %b expected %b", status, 6'b100001); end
        step(); drv_obs(1'b1, 10'd401, 9'd300, 9'h155, 1'b0); drv_plr(1'b1, 10'd20, 9'd20, 9'h020, 1'b0); #1;
        n_chk++; if (VGA_x !== 10'd400) begin n_fail++; $display("FAIL areset_c2_x: got %0d expected 400", VGA_x); end
        #1; Resetn = 1'b0; #1;
        n_chk++; if (status !== 6'b000000) begin n_fail++; $display("FAIL areset_status: got %b expected %b", status, 6'b000000); end
        n_chk++; if ({VGA_x, VGA_y, VGA_color} !== 28'd0) begin n_fail++; $display("FAIL areset_pixel: got %h expected 0", {VGA_x, VGA_y, VGA_color}); end
        @(negedge Clock);
        Resetn = 1'b1;
        step(); #1;
        n_chk++; if (status !== 6'b100001) begin n_fail++; $display("FAIL areset_regrant: got %b expected %b", status, 6'b100001); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        Resetn = 1'b0;
        drv_obs(1'b0, 10'd0, 9'd0, 9'd0, 1'b0);
        drv_plr(1'b0, 10'd0, 9'd0, 9'd0, 1'b0);
        test_reset();
        test_single_burst();
        test_race();
        test_stall();
        test_timeout();
        test_clip();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
